ps2_kb_writer: RTL

// - Keyboard-side writer into the KB_INFO region (0x0050_0000) of the memory map; the CPU reads the word it leaves there.
// - Deserialises PS/2 scan-code set 2 frames and folds E0/F0 prefixes into one event word.
// - Issues a single-cycle write (kb_wraddr/kb_wrdata/kb_we) per complete key event.
// - Sits between the board PS/2 pins and the memory map's keyboard write port.

---
 rtl/ps2_kb_writer_pkg.sv | 20 ++
 rtl/ps2_kb_writer_rx.sv | 77 +++++++
 rtl/ps2_kb_writer.sv | 56 +++++
 3 files changed

// File: rtl/ps2_kb_writer_pkg.sv
// ps2_kb_writer_pkg: shared keyboard event constants, receiver states and event-word packing
package ps2_kb_writer_pkg;
  localparam logic [7:0] KB_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] KB_PREFIX_BRK = 8'hF0;
  localparam int SEQ_LSB  = 24;
  localparam int EXT_BIT  = 16;
  localparam int MAKE_BIT = 8;
  localparam int CODE_LSB = 0;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  function automatic logic [31:0] kb_event(input logic [7:0] seq, input logic ext, input logic make,
                                           input logic [7:0] code);
    logic [31:0] w;
    w = '0;
    w[SEQ_LSB +: 8] = seq;
    w[EXT_BIT] = ext;
    w[MAKE_BIT] = make;
    w[CODE_LSB +: 8] = code;
    return w;
  endfunction
endpackage

// File: rtl/ps2_kb_writer_rx.sv
// ps2_rx_frame: PS/2 pin synchronisers, falling-edge detect, frame FSM, timeout and optional parity check.
// Odd-parity qualification is enabled by defining KB_PARITY_CHECK_EN.
module ps2_rx_frame
  import ps2_kb_writer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic fall, bit_in, frame_ok;
  rx_state_t state, state_next;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic [CW-1:0] cnt;
`ifdef KB_PARITY_CHECK_EN
  logic par;
`endif
  // synchronisers idle high so reset never fakes a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end
  assign fall = clk_sync[2] & ~clk_sync[1];
  assign bit_in = data_sync[1];
  assign byte_data = sr;
  assign timeout = (state != RX_IDLE) && !fall && (cnt == CW'(TIMEOUT_CYCLES - 1));
`ifdef KB_PARITY_CHECK_EN
  assign frame_ok = bit_in & (^{sr, par});
`else
  assign frame_ok = bit_in;
`endif
  always_comb begin
    state_next = timeout ? RX_IDLE :
                 !fall ? state :
                 state == RX_IDLE ? (bit_in ? RX_IDLE : RX_DATA) :
                 state == RX_DATA ? (bit_cnt == 3'd7 ? RX_PARITY : RX_DATA) :
                 state == RX_PARITY ? RX_STOP : RX_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      bit_cnt <= '0;
      sr <= '0;
      cnt <= '0;
      byte_valid <= 1'b0;
`ifdef KB_PARITY_CHECK_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt <= (fall || state == RX_IDLE || timeout) ? '0 : cnt + CW'(1);
      byte_valid <= fall && state == RX_STOP && frame_ok;
      if (fall && state == RX_IDLE) bit_cnt <= '0;
      if (fall && state == RX_DATA) begin
        sr <= {bit_in, sr[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef KB_PARITY_CHECK_EN
      if (fall && state == RX_PARITY) par <= bit_in;
`endif
    end
  end
endmodule

// File: rtl/ps2_kb_writer.sv
// ps2_kb_writer: folds PS/2 set-2 E0/F0 prefixes into one event word and writes it to KB_INFO.
// Parity qualification of frames is enabled by defining KB_PARITY_CHECK_EN.
module ps2_kb_writer
  import ps2_kb_writer_pkg::*;
#(
  parameter logic [31:0] KB_BASE        = 32'h00500000,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] kb_wraddr,
  output logic [31:0] kb_wrdata,
  output logic        kb_we
);
  logic byte_valid, timeout, ext, brk, is_ext, is_brk;
  logic [7:0] byte_data, seq;
  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .timeout(timeout)
  );
  assign kb_wraddr = KB_BASE;
  assign is_ext = byte_data == KB_PREFIX_EXT;
  assign is_brk = byte_data == KB_PREFIX_BRK;
  // an abandoned frame also abandons any prefix collected before it
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_we <= 1'b0;
      kb_wrdata <= '0;
      seq <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
    end else begin
      kb_we <= byte_valid && !is_ext && !is_brk;
      if (byte_valid) begin
        if (is_ext) ext <= 1'b1;
        else if (is_brk) brk <= 1'b1;
        else begin
          kb_wrdata <= kb_event(seq, ext, ~brk, byte_data);
          seq <= seq + 8'd1;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end else if (timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end
endmodule
